// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared pcgen select codes, reset PC and fetch FSM state encodings
package fetch_ctrl_pkg;
  localparam logic [1:0] PC_SEL_STATE_ADD         = 2'd0;
  localparam logic [1:0] PC_SEL_STATE_BRANCH_JUMP = 2'd1;
  localparam logic [1:0] PC_SEL_STATE_REG_JUMP    = 2'd2;
  localparam logic [31:0] INITIAL_PC_VALUE = 32'h0000_0000;
  typedef enum logic [1:0] {
    FETCH_ST_IDLE = 2'd0,
    FETCH_ST_REQ  = 2'd1,
    FETCH_ST_RSP  = 2'd2,
    FETCH_ST_HOLD = 2'd3
  } fetch_st_e;
endpackage

// File: rtl/fetch_ctrl_pcgen.sv
// fetch_ctrl_pcgen: next-PC mux (sequential increment, branch/jump target, register-jump target)
//   i_pc, i_sel           current PC and select from fetch_ctrl
//   i_brjmp_target        branch/jump target
//   i_jump_reg_target     register-jump target
//   o_npc                 selected next PC
module fetch_ctrl_pcgen
  import fetch_ctrl_pkg::*;
#(
  parameter int AWIDTH    = 32,
  parameter int ADDR_BYTE = AWIDTH >> 3
) (
  input  logic [AWIDTH-1:0] i_pc,
  input  logic [1:0]        i_sel,
  input  logic [AWIDTH-1:0] i_brjmp_target,
  input  logic [AWIDTH-1:0] i_jump_reg_target,
  output logic [AWIDTH-1:0] o_npc
);
  always_comb begin
    o_npc = i_sel == PC_SEL_STATE_REG_JUMP    ? i_jump_reg_target :
            i_sel == PC_SEL_STATE_BRANCH_JUMP ? i_brjmp_target    :
                                                i_pc + AWIDTH'(ADDR_BYTE);
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC, one outstanding imem request, handoff to decode
//   i_clk, i_rstn                 clock, async active-low reset
//   i_redirect_*, *_target        redirect requests (register jump beats branch)
//   o_imem_req/addr, i_imem_*     imem req/gnt/rvalid handshake
//   o_inst_valid/inst/inst_pc     instruction to decode, i_inst_ready accepts it
//   o_pc, o_pc_sel                PC register and select driven into pcgen
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int ADDR_BYTE = AWIDTH >> 3
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_redirect_br,
  input  logic [AWIDTH-1:0] i_brjmp_target,
  input  logic              i_redirect_reg,
  input  logic [AWIDTH-1:0] i_jump_reg_target,
  output logic              o_imem_req,
  output logic [AWIDTH-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [DWIDTH-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  output logic [DWIDTH-1:0] o_inst,
  output logic [AWIDTH-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  output logic [AWIDTH-1:0] o_pc,
  output logic [1:0]        o_pc_sel
);
  fetch_st_e         state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d, npc;
  logic [DWIDTH-1:0] inst_q, inst_d;
  logic              kill_q, kill_d, redirect;

  // Redirects are ignored in IDLE so the select reads ADD while in reset.
  assign redirect = (i_redirect_reg | i_redirect_br) && state_q != FETCH_ST_IDLE;
  assign o_pc_sel = !redirect      ? PC_SEL_STATE_ADD      :
                    i_redirect_reg ? PC_SEL_STATE_REG_JUMP : PC_SEL_STATE_BRANCH_JUMP;

  fetch_ctrl_pcgen #(.AWIDTH(AWIDTH), .ADDR_BYTE(ADDR_BYTE)) u_pcgen (
    .i_pc              (pc_q),
    .i_sel             (o_pc_sel),
    .i_brjmp_target    (i_brjmp_target),
    .i_jump_reg_target (i_jump_reg_target),
    .o_npc             (npc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = redirect ? npc : pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      FETCH_ST_IDLE: state_d = FETCH_ST_REQ;
      FETCH_ST_REQ: begin
        // A redirect accepted together with gnt leaves a stale response in flight.
        if (i_imem_gnt) begin
          state_d = FETCH_ST_RSP;
          kill_d  = redirect;
        end
      end
      FETCH_ST_RSP: begin
        if (i_imem_rvalid) begin
          kill_d = 1'b0;
          if (!redirect && !kill_q) begin
            inst_d    = i_imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = npc;
            state_d   = FETCH_ST_HOLD;
          end else begin
            state_d = FETCH_ST_REQ;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      FETCH_ST_HOLD: if (redirect || i_inst_ready) state_d = FETCH_ST_REQ;
      default: state_d = FETCH_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= FETCH_ST_IDLE;
      pc_q      <= AWIDTH'(INITIAL_PC_VALUE);
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign o_imem_req   = state_q == FETCH_ST_REQ;
  assign o_imem_addr  = pc_q;
  assign o_pc         = pc_q;
  assign o_inst_valid = state_q == FETCH_ST_HOLD;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;
  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_redirect_br = 1'b0, i_redirect_reg = 1'b0;
  logic [31:0] i_brjmp_target = '0, i_jump_reg_target = '0;
  logic        o_imem_req, i_imem_gnt = 1'b0, i_imem_rvalid = 1'b0;
  logic [31:0] o_imem_addr, i_imem_rdata = '0;
  logic        o_inst_valid, i_inst_ready = 1'b0;
  logic [31:0] o_inst, o_inst_pc, o_pc;
  logic [1:0]  o_pc_sel;
  int checks = 0, failures = 0;

  fetch_ctrl dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_redirect_br(i_redirect_br), .i_brjmp_target(i_brjmp_target),
    .i_redirect_reg(i_redirect_reg), .i_jump_reg_target(i_jump_reg_target),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready), .o_pc(o_pc), .o_pc_sel(o_pc_sel)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic reach_hold(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] n;
    n = a + 32'd4;
    check("req", o_imem_req, 1);
    check("addr", o_imem_addr, a);
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    check("rsp_req", o_imem_req, 0);
    check("rsp_valid", o_inst_valid, 0);
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = d;
    step();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'hDEAD_BEEF;
    check("valid", o_inst_valid, 1);
    check("inst", o_inst, d);
    check("inst_pc", o_inst_pc, a);
    check("pc_inc", o_pc, n);
  endtask

  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input int stall);
    reach_hold(a, d);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", o_inst_valid, 1);
      check("stall_inst", o_inst, d);
      check("stall_inst_pc", o_inst_pc, a);
      check("stall_no_req", o_imem_req, 0);
    end
    i_inst_ready = 1'b1;
    step();
    i_inst_ready = 1'b0;
    check("accepted_valid", o_inst_valid, 0);
  endtask

  initial begin
    step();
    step();
    check("rst_pc", o_pc, 0);
    check("rst_req", o_imem_req, 0);
    check("rst_valid", o_inst_valid, 0);
    check("rst_inst", o_inst, 0);
    check("rst_inst_pc", o_inst_pc, 0);
    check("rst_sel", o_pc_sel, PC_SEL_STATE_ADD);
    i_rstn = 1'b1;
    step();
    fetch_one(32'h0, 32'h1111_0001, 0);
    fetch_one(32'h4, 32'h1111_0002, 5);
    fetch_one(32'h8, 32'h1111_0003, 0);
    // Branch redirect while waiting for the response: response dropped.
    check("pre_br_addr", o_imem_addr, 32'hC);
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    i_redirect_br = 1'b1;
    i_brjmp_target = 32'h100;
    #1;
    check("br_sel", o_pc_sel, PC_SEL_STATE_BRANCH_JUMP);
    step();
    i_redirect_br = 1'b0;
    check("br_pc", o_pc, 32'h100);
    check("br_no_req", o_imem_req, 0);
    i_imem_rvalid = 1'b1;
    i_imem_rdata = 32'hBAD0_0001;
    step();
    i_imem_rvalid = 1'b0;
    check("killed_valid", o_inst_valid, 0);
    fetch_one(32'h100, 32'h2222_0001, 0);
    // Register jump beats branch in the same cycle.
    i_redirect_reg = 1'b1;
    i_jump_reg_target = 32'h200;
    i_redirect_br = 1'b1;
    i_brjmp_target = 32'h300;
    #1;
    check("prio_sel", o_pc_sel, PC_SEL_STATE_REG_JUMP);
    step();
    i_redirect_reg = 1'b0;
    i_redirect_br = 1'b0;
    fetch_one(32'h200, 32'h3333_0001, 0);
    // Redirect coincident with rvalid: data dropped, no kill left behind.
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata = 32'hBAD0_0002;
    i_redirect_br = 1'b1;
    i_brjmp_target = 32'h300;
    step();
    i_imem_rvalid = 1'b0;
    i_redirect_br = 1'b0;
    check("coinc_valid", o_inst_valid, 0);
    fetch_one(32'h300, 32'h4444_0001, 0);
    // Redirect in HOLD wins over ready.
    reach_hold(32'h304, 32'h5555_0001);
    i_inst_ready = 1'b1;
    i_redirect_reg = 1'b1;
    i_jump_reg_target = 32'h400;
    step();
    i_inst_ready = 1'b0;
    i_redirect_reg = 1'b0;
    check("hold_squash_valid", o_inst_valid, 0);
    check("hold_pc", o_pc, 32'h400);
    // PC wrap.
    i_redirect_br = 1'b1;
    i_brjmp_target = 32'hFFFF_FFFC;
    step();
    i_redirect_br = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h6666_0001, 0);
    check("wrap_addr", o_imem_addr, 32'h0);
    fetch_one(32'h0, 32'h7777_0001, 0);
    // Async reset mid-fetch, late rvalid after release.
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    i_rstn = 1'b0;
    #1;
    check("arst_pc", o_pc, 0);
    check("arst_req", o_imem_req, 0);
    step();
    i_rstn = 1'b1;
    i_imem_rvalid = 1'b1;
    i_imem_rdata = 32'hBAD0_0003;
    step();
    check("late_req", o_imem_req, 1);
    check("late_addr", o_imem_addr, INITIAL_PC_VALUE);
    step();
    i_imem_rvalid = 1'b0;
    check("late_valid", o_inst_valid, 0);
    fetch_one(32'h0, 32'h8888_0001, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
